ddr_axi_slave_mem: RTL and testbench

//  AXI4 slave memory that answers the cache-side DDR master in place of the DDR2 controller.
//  - 128-bit data, 27-bit byte address, INCR bursts. Contents are held in on-chip block RAM.
//  - Used for simulation and for FPGA bring-up of the dmem cache/ddr_master path without MIG.
//  - One transaction at a time: single-port RAM, read and write are arbitrated.

---
 rtl/ddr_axi_pkg.sv | 26 ++
 rtl/sp_bram_be.sv | 32 +++
 rtl/ddr_axi_slave_mem.sv | 169 ++++++++++++++++
 tb/tb_ddr_axi_slave_mem.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_axi_pkg.sv
// Shared types and constants for the AXI4 slave memory.
//   resp_e     : AXI response codes driven on BRESP/RRESP
//   state_e    : transaction FSM states
//   BURST_INCR : only burst type served
//   SIZE_16B   : only beat size served (one 128-bit word per beat)
package ddr_axi_pkg;
  localparam int ADDR_W_DEF     = 27;
  localparam int DATA_W_DEF     = 128;
  localparam int DEPTH_LOG2_DEF = 14;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16B   = 3'b100;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_BRESP,
    ST_RREQ,
    ST_RDATA
  } state_e;
endpackage

// File: rtl/sp_bram_be.sv
// Single-port block RAM with per-byte write enables and a registered read.
//   clk_i   : clock
//   en_i    : port enable; with we_i==0 it is a read, rdata_o updates next cycle
//   we_i    : per-byte write enables
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : read data, holds its value until the next read
module sp_bram_be #(
  parameter int DEPTH_LOG2 = 14,
  parameter int DATA_W     = 128
) (
  input  logic                    clk_i,
  input  logic                    en_i,
  input  logic [DATA_W/8-1:0]     we_i,
  input  logic [DEPTH_LOG2-1:0]   addr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  output logic [DATA_W-1:0]       rdata_o
);
  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DATA_W/8; b++)
        if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      // Output register only moves on reads so a stalled beat stays stable.
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/ddr_axi_slave_mem.sv
// AXI4 slave memory standing in for the DDR2 controller behind the cache's
// DDR master. One burst at a time against a single-port byte-enable RAM.
//   clk, rst         : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*  : write address, data and response channels
//   S_AXI_AR*/R*     : read address and data channels
// Word index is addr[DEPTH_LOG2+3:4]; other address bits alias. Read beats
// take two cycles each (RAM read issue, then present).
module ddr_axi_slave_mem
  import ddr_axi_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   S_AXI_AWADDR,
  input  logic [7:0]          S_AXI_AWLEN,
  input  logic [2:0]          S_AXI_AWSIZE,
  input  logic [1:0]          S_AXI_AWBURST,
  input  logic                S_AXI_AWVALID,
  output logic                S_AXI_AWREADY,
  input  logic [DATA_W-1:0]   S_AXI_WDATA,
  input  logic [DATA_W/8-1:0] S_AXI_WSTRB,
  input  logic                S_AXI_WLAST,
  input  logic                S_AXI_WVALID,
  output logic                S_AXI_WREADY,
  output logic [1:0]          S_AXI_BRESP,
  output logic                S_AXI_BVALID,
  input  logic                S_AXI_BREADY,
  input  logic [ADDR_W-1:0]   S_AXI_ARADDR,
  input  logic [7:0]          S_AXI_ARLEN,
  input  logic [2:0]          S_AXI_ARSIZE,
  input  logic [1:0]          S_AXI_ARBURST,
  input  logic                S_AXI_ARVALID,
  output logic                S_AXI_ARREADY,
  output logic [DATA_W-1:0]   S_AXI_RDATA,
  output logic [1:0]          S_AXI_RRESP,
  output logic                S_AXI_RLAST,
  output logic                S_AXI_RVALID,
  input  logic                S_AXI_RREADY
);
  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [7:0]            len_q, len_d, cnt_q, cnt_d;
  logic                  err_q, err_d, prio_q, prio_d;

  logic                  aw_rdy, ar_rdy, w_rdy, b_vld, r_vld, last;
  logic                  ram_en;
  logic [DATA_W/8-1:0]   ram_we;
  logic [DATA_W-1:0]     ram_rdata;

  // Aliased address bits are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[3:0], S_AXI_AWADDR[ADDR_W-1:DEPTH_LOG2+4],
                              S_AXI_ARADDR[3:0], S_AXI_ARADDR[ADDR_W-1:DEPTH_LOG2+4]};

  assign last = (cnt_q == len_q);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    prio_d  = prio_q;
    aw_rdy  = 1'b0;
    ar_rdy  = 1'b0;
    w_rdy   = 1'b0;
    b_vld   = 1'b0;
    r_vld   = 1'b0;
    ram_en  = 1'b0;
    ram_we  = '0;
    case (state_q)
      ST_IDLE: begin
        aw_rdy = S_AXI_AWVALID & (prio_q | ~S_AXI_ARVALID);
        ar_rdy = S_AXI_ARVALID & ~aw_rdy;
        // Priority only flips when both channels actually contended.
        if (S_AXI_AWVALID & S_AXI_ARVALID) prio_d = ~prio_q;
        if (aw_rdy) begin
          addr_d  = S_AXI_AWADDR[DEPTH_LOG2+3:4];
          len_d   = S_AXI_AWLEN;
          cnt_d   = '0;
          err_d   = (S_AXI_AWSIZE != SIZE_16B) | (S_AXI_AWBURST != BURST_INCR);
          state_d = ST_WDATA;
        end else if (ar_rdy) begin
          addr_d  = S_AXI_ARADDR[DEPTH_LOG2+3:4];
          len_d   = S_AXI_ARLEN;
          cnt_d   = '0;
          err_d   = (S_AXI_ARSIZE != SIZE_16B) | (S_AXI_ARBURST != BURST_INCR);
          state_d = ST_RREQ;
        end
      end
      ST_WDATA: begin
        w_rdy = 1'b1;
        if (S_AXI_WVALID) begin
          ram_en = 1'b1;
          ram_we = err_q ? '0 : S_AXI_WSTRB;
          // A misplaced WLAST only flags the error; len still ends the burst.
          if (S_AXI_WLAST != last) err_d = 1'b1;
          if (last) begin
            state_d = ST_BRESP;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = addr_q + 1'b1;
          end
        end
      end
      ST_BRESP: begin
        b_vld = 1'b1;
        if (S_AXI_BREADY) state_d = ST_IDLE;
      end
      ST_RREQ: begin
        ram_en  = 1'b1;
        state_d = ST_RDATA;
      end
      ST_RDATA: begin
        r_vld = 1'b1;
        if (S_AXI_RREADY) begin
          if (last) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            addr_d  = addr_q + 1'b1;
            state_d = ST_RREQ;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      prio_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      prio_q  <= prio_d;
    end
  end

  sp_bram_be #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_ram (
    .clk_i   (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (addr_q),
    .wdata_i (S_AXI_WDATA),
    .rdata_o (ram_rdata)
  );

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_WREADY  = w_rdy;
  assign S_AXI_BVALID  = b_vld;
  assign S_AXI_BRESP   = (b_vld & err_q) ? SLVERR : OKAY;
  assign S_AXI_RVALID  = r_vld;
  assign S_AXI_RRESP   = (r_vld & err_q) ? SLVERR : OKAY;
  assign S_AXI_RLAST   = r_vld & last;
  assign S_AXI_RDATA   = (r_vld & ~err_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_ddr_axi_slave_mem.sv
// Directed bench for ddr_axi_slave_mem. A word-level memory model and
// expected-beat queues predict every R and B beat; one negedge process
// compares DUT outputs to them, and directed literals pin the model.
module tb_ddr_axi_slave_mem;
  localparam int AW = 27, DW = 128, DL = 14, D = 1 << DL;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
  logic [7:0]    S_AXI_AWLEN = '0, S_AXI_ARLEN = '0;
  logic [2:0]    S_AXI_AWSIZE = '0, S_AXI_ARSIZE = '0;
  logic [1:0]    S_AXI_AWBURST = '0, S_AXI_ARBURST = '0;
  logic          S_AXI_AWVALID = 0, S_AXI_ARVALID = 0, S_AXI_WVALID = 0, S_AXI_WLAST = 0;
  logic          S_AXI_BREADY = 0, S_AXI_RREADY = 0;
  logic [DW-1:0] S_AXI_WDATA = '0;
  logic [15:0]   S_AXI_WSTRB = '0;
  logic          S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST;
  logic [1:0]    S_AXI_BRESP, S_AXI_RRESP;
  logic [DW-1:0] S_AXI_RDATA;

  ddr_axi_slave_mem dut (
    .clk(clk), .rst(rst),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  typedef struct { logic [127:0] data; logic last; logic [1:0] resp; } rbeat_t;
  rbeat_t       exp_r[$];
  logic [1:0]   exp_b[$];
  logic [127:0] mem_m [int];
  logic [127:0] last_rdata = '0;
  logic [1:0]   last_bresp = '0;
  int           pass_cnt = 0, tot_cnt = 0;
  int           w_idx, w_len;
  bit           w_err, chk_en = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Compare process: every cycle with a live R or B beat is checked.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      if (S_AXI_RVALID) begin
        if (exp_r.size() == 0) check("r_unexpected", S_AXI_RVALID, 0);
        else begin
          check("rdata", S_AXI_RDATA, exp_r[0].data);
          check("rlast", S_AXI_RLAST, exp_r[0].last);
          check("rresp", S_AXI_RRESP, exp_r[0].resp);
          if (S_AXI_RREADY) begin last_rdata = S_AXI_RDATA; void'(exp_r.pop_front()); end
        end
      end
      if (S_AXI_BVALID) begin
        if (exp_b.size() == 0) check("b_unexpected", S_AXI_BVALID, 0);
        else begin
          check("bresp", S_AXI_BRESP, exp_b[0]);
          if (S_AXI_BREADY) begin last_bresp = S_AXI_BRESP; void'(exp_b.pop_front()); end
        end
      end
      if (S_AXI_WREADY | S_AXI_BVALID | S_AXI_RVALID) begin
        check("busy_no_accept", {S_AXI_AWREADY, S_AXI_ARREADY}, 0);
        check("one_channel", $countones({S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID}), 1);
      end
    end
  end

  task automatic aw_book(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    w_idx = int'(a[DL+3:4]);
    w_len = int'(l);
    w_err = (s != 3'b100) || (b != 2'b01);
  endtask

  task automatic aw_send(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    bit hs = 0; int n = 0;
    S_AXI_AWADDR = a; S_AXI_AWLEN = l; S_AXI_AWSIZE = s; S_AXI_AWBURST = b; S_AXI_AWVALID = 1;
    while (!hs && n < 50) begin @(negedge clk); hs = S_AXI_AWREADY; @(posedge clk); #1; n++; end
    S_AXI_AWVALID = 0;
    if (!hs) check("aw_timeout", 0, 1);
    aw_book(a, l, s, b);
  endtask

  // Beat i carries base+i; bad_beat >= 0 inverts WLAST on that beat.
  task automatic w_beats(input logic [127:0] base, input logic [15:0] strb, input int bad_beat, input int bdelay);
    int n;
    for (int i = 0; i <= w_len; i++) begin
      bit hs = 0; int w = (w_idx + i) % D;
      logic [127:0] cur;
      S_AXI_WDATA = base + 128'(i); S_AXI_WSTRB = strb;
      S_AXI_WLAST = (i == w_len) ^ (i == bad_beat); S_AXI_WVALID = 1;
      n = 0;
      while (!hs && n < 50) begin @(negedge clk); hs = S_AXI_WREADY; @(posedge clk); #1; n++; end
      if (!hs) check("w_timeout", 0, 1);
      if (!w_err) begin
        cur = mem_m.exists(w) ? mem_m[w] : '0;
        for (int k = 0; k < 16; k++) if (strb[k]) cur[8*k +: 8] = S_AXI_WDATA[8*k +: 8];
        mem_m[w] = cur;
      end
      if (S_AXI_WLAST != (i == w_len)) w_err = 1;
    end
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    exp_b.push_back(w_err ? 2'b10 : 2'b00);
    @(negedge clk); check("b_latency", S_AXI_BVALID, 1);
    @(posedge clk); #1;
    repeat (bdelay) begin @(posedge clk); #1; end
    S_AXI_BREADY = 1; n = 0;
    while (exp_b.size() > 0 && n < 50) begin @(posedge clk); #1; n++; end
    S_AXI_BREADY = 0;
    if (exp_b.size() > 0) begin check("b_timeout", 0, 1); exp_b.delete(); end
  endtask

  task automatic ar_book(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int idx = int'(a[DL+3:4]);
    bit e = (s != 3'b100) || (b != 2'b01);
    for (int i = 0; i <= int'(l); i++) begin
      rbeat_t r;
      r.data = e ? '0 : mem_m[(idx + i) % D];
      r.last = (i == int'(l));
      r.resp = e ? 2'b10 : 2'b00;
      exp_r.push_back(r);
    end
    @(negedge clk); check("r_lat_rreq", S_AXI_RVALID, 0);
    @(negedge clk); check("r_lat_first", S_AXI_RVALID, 1);
    @(posedge clk); #1;
  endtask

  task automatic ar_send(input logic [AW-1:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    bit hs = 0; int n = 0;
    S_AXI_ARADDR = a; S_AXI_ARLEN = l; S_AXI_ARSIZE = s; S_AXI_ARBURST = b; S_AXI_ARVALID = 1;
    while (!hs && n < 50) begin @(negedge clk); hs = S_AXI_ARREADY; @(posedge clk); #1; n++; end
    S_AXI_ARVALID = 0;
    if (!hs) check("ar_timeout", 0, 1);
    ar_book(a, l, s, b);
  endtask

  task automatic r_drain(input bit toggle);
    int n = 0;
    S_AXI_RREADY = 1;
    while (exp_r.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      if (toggle) S_AXI_RREADY = ~S_AXI_RREADY;
      n++;
    end
    S_AXI_RREADY = 0;
    if (exp_r.size() > 0) begin check("r_timeout", 0, 1); exp_r.delete(); end
  endtask

  // Raise AW and AR together (single-beat bursts) and check who wins.
  task automatic contend(input bit wr_wins, input logic [AW-1:0] wa, input logic [127:0] wd, input logic [AW-1:0] ra);
    S_AXI_AWADDR = wa; S_AXI_AWLEN = 0; S_AXI_AWSIZE = 3'b100; S_AXI_AWBURST = 2'b01; S_AXI_AWVALID = 1;
    S_AXI_ARADDR = ra; S_AXI_ARLEN = 0; S_AXI_ARSIZE = 3'b100; S_AXI_ARBURST = 2'b01; S_AXI_ARVALID = 1;
    @(negedge clk);
    check("arb_awready", S_AXI_AWREADY, wr_wins);
    check("arb_arready", S_AXI_ARREADY, !wr_wins);
    @(posedge clk); #1;
    if (wr_wins) begin
      S_AXI_AWVALID = 0; aw_book(wa, 0, 3'b100, 2'b01); w_beats(wd, 16'hFFFF, -1, 0);
      ar_send(ra, 0, 3'b100, 2'b01); r_drain(0);
    end else begin
      S_AXI_ARVALID = 0; ar_book(ra, 0, 3'b100, 2'b01); r_drain(0);
      aw_send(wa, 0, 3'b100, 2'b01); w_beats(wd, 16'hFFFF, -1, 0);
    end
  endtask

  localparam logic [127:0] T1_DATA = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] MERGED  = {96'hFFFFFFFF_FFFFFFFF_FFFFFFFF, 32'h0};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_ready", {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY}, 0);
    check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_RLAST}, 0);
    check("rst_resp", {S_AXI_BRESP, S_AXI_RRESP}, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    chk_en = 1;
    @(posedge clk); #1;

    // Arbitration: write, then read, then write wins again.
    contend(1, 27'h100, 128'hA5A5A5A5_00000000_5A5A5A5A_00000000, 27'h100);
    check("arb1_rdata_lit", last_rdata, 128'hA5A5A5A5_00000000_5A5A5A5A_00000000);
    contend(0, 27'h200, 128'h2222, 27'h100);
    contend(1, 27'h300, 128'h3333, 27'h200);
    check("arb3_rdata_lit", last_rdata, 128'h2222);

    // Single write and readback, B held off for two cycles.
    aw_send(27'h10, 0, 3'b100, 2'b01); w_beats(T1_DATA, 16'hFFFF, -1, 2);
    check("t1_model_lit", mem_m[1], T1_DATA);
    ar_send(27'h10, 0, 3'b100, 2'b01); r_drain(0);
    check("t1_rdata_lit", last_rdata, T1_DATA);
    ar_send(27'h4000010, 0, 3'b100, 2'b01); r_drain(0);
    check("alias_rdata_lit", last_rdata, T1_DATA);

    // Byte-strobe merge.
    aw_send(27'h20, 0, 3'b100, 2'b01); w_beats({128{1'b1}}, 16'hFFFF, -1, 0);
    aw_send(27'h20, 0, 3'b100, 2'b01); w_beats('0, 16'h000F, -1, 0);
    ar_send(27'h20, 0, 3'b100, 2'b01); r_drain(0);
    check("t2_merge_lit", last_rdata, MERGED);

    // Burst wrapping past the top of the RAM, read back with RREADY toggling.
    aw_send(27'h3FFE0, 3, 3'b100, 2'b01); w_beats(128'h1, 16'hFFFF, -1, 0);
    check("t3_model_w0", mem_m[0], 128'h3);
    check("t3_model_w1", mem_m[1], 128'h4);
    ar_send(27'h3FFE0, 3, 3'b100, 2'b01); r_drain(1);
    check("t3_last_lit", last_rdata, 128'h4);
    ar_send(27'h0, 0, 3'b100, 2'b01); r_drain(0);
    check("t3_word0_lit", last_rdata, 128'h3);

    // Errors: bad size leaves memory alone; early WLAST flags SLVERR.
    aw_send(27'h20, 0, 3'b010, 2'b01); w_beats(128'hDEAD, 16'hFFFF, -1, 0);
    check("t4a_bresp_lit", last_bresp, 2'b10);
    ar_send(27'h20, 0, 3'b100, 2'b01); r_drain(0);
    check("t4a_unchanged_lit", last_rdata, MERGED);
    aw_send(27'h30, 1, 3'b100, 2'b01); w_beats(128'h77, 16'hFFFF, 0, 0);
    check("t4b_bresp_lit", last_bresp, 2'b10);
    ar_send(27'h10, 0, 3'b010, 2'b01); r_drain(0);
    check("rd_err_zero_lit", last_rdata, 0);

    // Reset during the first of four read beats.
    aw_send(27'h400, 3, 3'b100, 2'b01); w_beats(128'hC0, 16'hFFFF, -1, 0);
    ar_send(27'h400, 3, 3'b100, 2'b01);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_r.delete();
    @(negedge clk);
    check("t6_rvalid", S_AXI_RVALID, 0);
    check("t6_idle_outs", {S_AXI_WREADY, S_AXI_BVALID, S_AXI_RLAST, S_AXI_AWREADY, S_AXI_ARREADY}, 0);
    @(posedge clk); #1;
    ar_send(27'h400, 3, 3'b100, 2'b01); r_drain(0);
    check("t6_rdata_lit", last_rdata, 128'hC3);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", pass_cnt, tot_cnt);
    $fatal(1);
  end
endmodule
